ip_psram_arbiter: RTL
=====================

IP_PSRAM_ARBITER -- requirements
Module: ip_psram_arbiter

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 a_rd, a_wr  input  1 each  port A read/write request level; held until a_ack.
REQ-004 a_address  input  22  port A byte address; a_wdata input 8, port A write data.
REQ-005 a_ack  output  1  one-cycle pulse: port A command issued to PSRAM.
REQ-006 a_rdata  output  8; a_rdata_en output 1: port A read data plus one-cycle valid strobe.
REQ-007 b_rd, b_wr, b_address[21:0], b_wdata[7:0], b_ack, b_rdata[7:0], b_rdata_en: port B, identical to port A.
REQ-008 rd, wr  output  1 each  PSRAM command strobes.
REQ-009 address  output  22; wdata output 8: PSRAM command address and data.
REQ-010 busy  input  1; rdata input 8; rdata_en input 1: PSRAM controller status and read return.

Function
REQ-011 PSRAM accepts a command on a cycle with (rd|wr)=1 and busy=0, raises busy the next cycle, and returns read data as a one-cycle rdata_en pulse no later than the cycle busy falls.
REQ-012 FSM states: IDLE, ISSUE, HOLD, WAIT; reset state IDLE.
REQ-013 IDLE: if any request is pending, latch the granted port, its op (rd takes precedence over wr when both are high on one port), address and wdata, then go to ISSUE.
REQ-014 ISSUE: drive rd or wr with the latched address/wdata; on the cycle busy=0, pulse the granted port's ack and go to HOLD; while busy=1, stay in ISSUE holding outputs.
REQ-015 HOLD: exactly one cycle, strobes low, busy ignored; then WAIT.
REQ-016 WAIT: write completes on first cycle busy=0; read completes on first cycle busy=0 with rdata_en seen in HOLD/WAIT or this cycle; on completion go to IDLE.
REQ-017 Read return: forward rdata to the granted port's xx_rdata with xx_rdata_en the cycle after PSRAM rdata_en; other port's rdata_en stays 0.
REQ-018 rdata_en outside HOLD/WAIT of a read is ignored.
REQ-019 rd, wr, ack: high only in ISSUE, never both high; address/wdata are 0 in IDLE.
REQ-020 Latency, idle PSRAM (busy=0): request at cycle N -> rd/wr at N+1 -> ack at N+1 -> next grant no earlier than N+3.
REQ-021 A requester dropping its request before ack is not cancelled once latched.
REQ-022 xx_rdata holds its last value until the next read to that port.

Reset
REQ-023 reset=1 at any state forces IDLE the next edge; all outputs 0; latched grant, op, address, wdata, rdata_en-seen flag and priority pointer cleared (pointer = A).
REQ-024 Reset mid-transfer: no ack or rdata_en pulse is generated for the aborted command.

Configuration
REQ-025 Macro IP_PSRAM_ARBITER_ROUND_ROBIN_EN defined: simultaneous requests go to the port not most recently granted; pointer updates on each ack.
REQ-026 Macro undefined: fixed priority, port A always wins ties; pointer logic absent.

Verification
REQ-027 A write 0x00_4000 <= 0x5A, busy=0 -> wr=1, address=0x004000, wdata=0x5A one cycle, a_ack same cycle, FSM back to IDLE after busy low.
REQ-028 B read 0x3F_FFFF, PSRAM returns 0xC3 with rdata_en 4 cycles after accept -> b_rdata=0xC3, b_rdata_en one cycle later, a_rdata_en=0.
REQ-029 A and B read requests raised same cycle, repeated 4 times -> with macro, grants A,B,A,B; without macro, all A while A keeps requesting.
REQ-030 busy=1 held 5 cycles at ISSUE -> rd held 5 cycles, ack only on the first busy=0 cycle, address stable.
REQ-031 reset pulsed in WAIT of a read, then rdata_en arrives -> no a_rdata_en/b_rdata_en, all outputs 0, next request served normally.
REQ-032 a_rd and a_wr both high -> single read issued, wr stays 0.

Source files
------------

// File: rtl/ip_psram_arbiter.sv
// Two-port (A/B) arbiter in front of a single PSRAM command interface.
// Optional macro IP_PSRAM_ARBITER_ROUND_ROBIN_EN selects round-robin tie-break (default: port A wins).
module ip_psram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_rd,
  input  logic        a_wr,
  input  logic [21:0] a_address,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  output logic        a_rdata_en,
  input  logic        b_rd,
  input  logic        b_wr,
  input  logic [21:0] b_address,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic        b_rdata_en,
  output logic        rd,
  output logic        wr,
  output logic [21:0] address,
  output logic [7:0]  wdata,
  input  logic        busy,
  input  logic [7:0]  rdata,
  input  logic        rdata_en
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT} state_t;

  state_t state;
  logic   gnt_b;
  logic   op_rd;
  logic   seen;
  logic   a_req;
  logic   b_req;
  logic   pick_b;
  logic   ack_now;
  logic   rd_take;
  logic   done;

  assign a_req = a_rd | a_wr;
  assign b_req = b_rd | b_wr;

`ifdef IP_PSRAM_ARBITER_ROUND_ROBIN_EN
  logic ptr_b;
  assign pick_b = b_req & (~a_req | ptr_b);
`else
  assign pick_b = b_req & ~a_req;
`endif

  // Ack must coincide with the cycle the PSRAM accepts, so it is decoded from state and busy.
  assign ack_now = (state == ISSUE) & ~busy & ~reset;
  assign a_ack   = ack_now & ~gnt_b;
  assign b_ack   = ack_now & gnt_b;

  assign rd_take = op_rd & rdata_en & ((state == HOLD) | (state == WAIT));
  assign done    = (state == WAIT) & ~busy & (~op_rd | seen | rdata_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt_b      <= 1'b0;
      op_rd      <= 1'b0;
      seen       <= 1'b0;
      rd         <= 1'b0;
      wr         <= 1'b0;
      address    <= '0;
      wdata      <= '0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      a_rdata_en <= 1'b0;
      b_rdata_en <= 1'b0;
`ifdef IP_PSRAM_ARBITER_ROUND_ROBIN_EN
      ptr_b      <= 1'b0;
`endif
    end else begin
      // read return stage: one register between PSRAM and the requesting port
      a_rdata_en <= rd_take & ~gnt_b;
      b_rdata_en <= rd_take & gnt_b;
      if (rd_take & ~gnt_b) a_rdata <= rdata;
      if (rd_take & gnt_b)  b_rdata <= rdata;
      if (rd_take) seen <= 1'b1;

      case (state)
        IDLE: begin
          if (a_req | b_req) begin
            gnt_b   <= pick_b;
            op_rd   <= pick_b ? b_rd : a_rd;
            rd      <= pick_b ? b_rd : a_rd;
            wr      <= pick_b ? ~b_rd : ~a_rd;
            address <= pick_b ? b_address : a_address;
            wdata   <= pick_b ? b_wdata : a_wdata;
            seen    <= 1'b0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (!busy) begin
            rd    <= 1'b0;
            wr    <= 1'b0;
            state <= HOLD;
`ifdef IP_PSRAM_ARBITER_ROUND_ROBIN_EN
            ptr_b <= ~gnt_b;
`endif
          end
        end
        HOLD: state <= WAIT;
        WAIT: begin
          if (done) begin
            address <= '0;
            wdata   <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
